normalizer32: RTL and testbench
===============================

NORMALIZER32 -- requirements
Module: normalizer32

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the count width at 5 bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 data_in  input  32  operand to normalize.
REQ-008 signed_mode  input  1  0 = count leading zeros; 1 = count redundant sign bits.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 data_out  output  32  normalized operand.
REQ-012 shift_amt  output  5  left-shift distance applied to produce data_out.
REQ-013 zero  output  1  operand has no normalized form.

Function
REQ-014 The block SHALL be an iterative left-shift normalizer that recovers the shift amount a left shift would need, with states IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE and rst_n is high; a request is accepted on an edge where in_valid & in_ready.
REQ-016 On acceptance the block SHALL load the working register with data_in, latch signed_mode, and clear the count to 0.
REQ-017 Degenerate operand: unsigned data_in == 0, or signed data_in == 0x0000_0000 or 0xFFFF_FFFF, SHALL go IDLE->DONE on the accepting edge, with zero=1, data_out=data_in and shift_amt=0.
REQ-018 Any other operand SHALL go IDLE->SHIFT on the accepting edge, with zero=0.
REQ-019 In SHIFT, the operand is normalized when reg[31]==1 (unsigned) or reg[31]!=reg[30] (signed).
REQ-020 On each SHIFT edge: if normalized, go to DONE with the register and count unchanged; otherwise shift reg left by 1 (zero fill) and increment the count by 1.
REQ-021 Latency: out_valid SHALL rise N+1 edges after the accepting edge, where N is the final shift_amt; for degenerate operands it rises on the accepting edge itself.
REQ-022 Shift range: unsigned N is 0..31 (31 for 0x0000_0001); signed N is 0..30 (30 for 0x0000_0001 and 0xFFFF_FFFE). The count SHALL never wrap.
REQ-023 In DONE, out_valid SHALL be 1 and data_out, shift_amt and zero SHALL be held stable until out_valid & out_ready.
REQ-024 On an edge with out_valid & out_ready the block SHALL go DONE->IDLE.
REQ-025 out_valid and in_ready SHALL never be 1 in the same cycle.
REQ-026 No new request is accepted in the completion cycle; the earliest next acceptance is one edge later.
REQ-027 in_valid, data_in and signed_mode SHALL be ignored outside IDLE.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 data_out, shift_amt and zero SHALL show the working register, count and zero flag in every state; they are meaningful only while out_valid=1.

Reset
REQ-030 While rst_n is low at an edge, the block SHALL enter IDLE and clear state, register, count and zero flag to 0.
REQ-031 After reset: out_valid=0, data_out=0, shift_amt=0, zero=0; in_ready is 0 during reset and 1 from the first edge after rst_n goes high.
REQ-032 A reset in SHIFT or DONE SHALL abort the operation with no result delivered, and the block SHALL resume from IDLE.

Verification
REQ-033 Unsigned 0x0000_0001 -> data_out 0x8000_0000, shift_amt 31, zero 0, out_valid 32 edges after acceptance.
REQ-034 Unsigned 0x8000_0000 -> data_out 0x8000_0000, shift_amt 0, out_valid 1 edge after acceptance; signed 0x4000_0000 -> shift_amt 0.
REQ-035 Signed 0xFFFF_FF00 -> data_out 0x8000_0000, shift_amt 23; signed 0x0000_00FF -> data_out 0x7F80_0000, shift_amt 23.
REQ-036 Unsigned 0x0000_0000 and signed 0xFFFF_FFFF -> zero 1, shift_amt 0, data_out equals the input, out_valid on the accepting edge.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/data_in -> outputs stable, in_ready 0, no acceptance; release -> IDLE next edge, in_ready 1.
REQ-038 Reset mid-SHIFT on 0x0000_0001 after 10 edges -> out_valid never asserted, outputs 0; a following request 0x0001_0000 yields shift_amt 15.

Source files
------------

// File: rtl/normalizer32.sv
// Iterative 32-bit left-shift normalizer: counts leading zeros (unsigned) or
// redundant sign bits (signed), one bit per clock, with valid/ready handshakes.
module normalizer32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic        signed_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [4:0]  shift_amt,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] work_r, work_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        mode_r, mode_s;
  logic        zero_r, zero_s;

  // All-zero (or all-one in signed mode) operands never reach a normalized form.
  function automatic logic is_degenerate(input logic [31:0] d, input logic m);
    logic result;
    if (m) begin
      result = (d == 32'h0000_0000) || (d == 32'hFFFF_FFFF);
    end else begin
      result = (d == 32'h0000_0000);
    end
    return result;
  endfunction

  function automatic logic is_normalized(input logic [31:0] d, input logic m);
    logic result;
    if (m) begin
      result = (d[31] != d[30]);
    end else begin
      result = d[31];
    end
    return result;
  endfunction

  // State, working register, count, mode and zero flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= 32'h0000_0000;
      cnt_r   <= 5'd0;
      mode_r  <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      zero_r  <= zero_s;
    end
  end

  // Next-state and datapath update; degenerate operands skip SHIFT entirely.
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    zero_s  = zero_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          work_s = data_in;
          mode_s = signed_mode;
          cnt_s  = 5'd0;
          if (is_degenerate(data_in, signed_mode)) begin
            zero_s  = 1'b1;
            state_s = DONE;
          end else begin
            zero_s  = 1'b0;
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // A non-degenerate operand normalizes within 31 shifts, so cnt never wraps.
        if (is_normalized(work_r, mode_r)) begin
          state_s = DONE;
        end else begin
          work_s = {work_r[30:0], 1'b0};
          cnt_s  = cnt_r + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_r == IDLE) && rst_n;
  assign out_valid = (state_r == DONE);
  assign data_out  = work_r;
  assign shift_amt = cnt_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_normalizer32.sv
// Randomized self-checking bench for normalizer32 against a bit-counting reference model.
module tb_normalizer32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [4:0]  shift_amt;
  logic        zero;

  int checks_cnt = 0;
  int errors_cnt = 0;

  normalizer32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .shift_amt   (shift_amt),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_degenerate(input logic [31:0] d, input logic m);
    return m ? ((d == 32'h0) || (d == 32'hFFFF_FFFF)) : (d == 32'h0);
  endfunction

  // Leading zeros (unsigned) or copies of the sign bit below bit 31 (signed).
  function automatic int ref_shift(input logic [31:0] d, input logic m);
    int n = 0;
    if (ref_degenerate(d, m)) return 0;
    if (!m) begin
      while (n < 31 && d[31-n] == 1'b0) n++;
    end else begin
      while (n < 30 && d[30-n] == d[31]) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency/result, optionally backpressure, then drain.
  task automatic run_op(input logic [31:0] d, input logic m, input int hold);
    int n;
    int edges;
    int guard;
    logic deg;
    logic [31:0] exp_data;
    deg = ref_degenerate(d, m);
    n = ref_shift(d, m);
    exp_data = deg ? d : (d << n);
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    data_in = d;
    signed_mode = m;
    tick();
    in_valid = 1'b0;
    data_in = $urandom;
    signed_mode = $urandom_range(0, 1);
    edges = 0;
    while (!out_valid && edges < 40) begin
      check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
      in_valid = $urandom_range(0, 1);
      tick();
      edges++;
    end
    in_valid = 1'b0;
    check_eq("latency", edges, deg ? 0 : n + 1);
    check_eq("data_out", data_out, exp_data);
    check_eq("shift_amt", {27'd0, shift_amt}, n);
    check_eq("zero", {31'd0, zero}, {31'd0, deg});
    check_eq("in_ready_done", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      data_in = $urandom;
      tick();
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_data_out", data_out, exp_data);
      check_eq("bp_shift_amt", {27'd0, shift_amt}, n);
      check_eq("bp_zero", {31'd0, zero}, {31'd0, deg});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("release_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rm;
    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in = 32'h0;
    signed_mode = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data_out", data_out, 32'h0);
    check_eq("rst_shift_amt", {27'd0, shift_amt}, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 1'b0, 0);
    run_op(32'h4000_0000, 1'b1, 0);
    run_op(32'hFFFF_FF00, 1'b1, 5);
    run_op(32'h0000_00FF, 1'b1, 0);
    run_op(32'h0000_0000, 1'b0, 2);
    run_op(32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h0000_0000, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h0000_0001, 1'b1, 0);
    run_op(32'hFFFF_FFFE, 1'b1, 0);

    // Abort a long operation mid-SHIFT with reset.
    in_valid = 1'b1;
    data_in = 32'h0000_0001;
    signed_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b0;
    tick();
    check_eq("abort_data_out", data_out, 32'h0);
    check_eq("abort_shift_amt", {27'd0, shift_amt}, 32'd0);
    check_eq("abort_zero", {31'd0, zero}, 32'd0);
    check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    run_op(32'h0001_0000, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      rm = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: rd = 32'h0;
        1: rd = 32'hFFFF_FFFF;
        2: rd = ~($urandom >> $urandom_range(0, 31));
        default: rd = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(rd, rm, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
